// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM window: loader state encoding, window constants
// and the word-index to bus-address mapping.
package sram_pkg;

    // One-hot encoding, matching the SRAM-side controller style.
    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_FILL = 5'b00010,
        ST_ADDR = 5'b00100,
        ST_DATA = 5'b01000,
        ST_FIN  = 5'b10000
    } load_state_e;

    localparam logic [31:0] SRAM_WIN_BASE = 32'h2000_0000;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam int          SRAM_AW       = 14;

    // The window is 64 KB, so a word index only ever touches haddr[15:2].
    function automatic logic [31:0] word_haddr(input logic [31:0]        base,
                                               input logic [SRAM_AW-1:0] word_idx);
        return base | {{(32 - SRAM_AW - 2){1'b0}}, word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Collects four stream bytes little-endian into one 32-bit word and flags the
// handshake that delivers the last byte of the word.
module byte_packer (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0] byte_idx;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            byte_idx <= 2'd0;
            word     <= 32'd0;
        end else if (clear) begin
            byte_idx <= 2'd0;
        end else if (accept) begin
            word[{byte_idx, 3'b000} +: 8] <= data;
            byte_idx                      <= byte_idx + 2'd1;
        end
    end

    // Combinational so the loader can leave FILL on the very edge that takes byte 3.
    assign word_done = accept && (byte_idx == 2'd3);

endmodule

// File: rtl/sram_stream_loader.sv
// AHB-lite write master that packs a byte stream into words and writes them to
// consecutive word addresses of the on-chip SRAM window.
module sram_stream_loader
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = SRAM_WIN_BASE
) (
    input  logic                hclk,
    input  logic                hreset,
    input  logic                start,
    input  logic [SRAM_AW-1:0]  start_addr,
    input  logic [SRAM_AW:0]    word_count,
    output logic                busy,
    output logic                done,
    output logic                err,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [7:0]          s_data,
    output logic                hsel,
    output logic [31:0]         haddr,
    output logic [2:0]          hsize,
    output logic                hwrite,
    output logic [31:0]         hwdata,
    input  logic                hready,
    input  logic                hresp
);

    load_state_e        state;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_AW:0]   remaining;

    logic               accept;
    logic               start_ok;
    logic               word_done;
    logic [31:0]        packed_word;

    assign accept   = s_valid && s_ready;
    assign start_ok = (state == ST_IDLE) && start;

    byte_packer u_packer (
        .hclk      (hclk),
        .hreset    (hreset),
        .clear     (start_ok),
        .accept    (accept),
        .data      (s_data),
        .word      (packed_word),
        .word_done (word_done)
    );

    // NOTE: every state and output register here uses <= so that all of them
    // update from the same pre-edge values; a blocking assignment would let a later
    // statement see the new value and silently reorder the pipeline.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            s_ready   <= 1'b0;
            hsel      <= 1'b0;
            hwrite    <= 1'b0;
            hsize     <= HSIZE_WORD;
            haddr     <= 32'd0;
            hwdata    <= 32'd0;
        end else begin
            done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err  <= 1'b0;
                        busy <= 1'b1;
                        if (word_count == '0) begin
                            state <= ST_FIN;
                        end else begin
                            addr      <= start_addr;
                            remaining <= word_count;
                            s_ready   <= 1'b1;
                            state     <= ST_FILL;
                        end
                    end
                end

                ST_FILL: begin
                    if (word_done) begin
                        s_ready <= 1'b0;
                        hsel    <= 1'b1;
                        hwrite  <= 1'b1;
                        haddr   <= word_haddr(BASE_ADDR, addr);
                        state   <= ST_ADDR;
                    end
                end

                // Address phase outputs simply hold while the slave stalls.
                ST_ADDR: begin
                    if (hready) begin
                        hsel   <= 1'b0;
                        hwrite <= 1'b0;
                        hwdata <= packed_word;
                        state  <= ST_DATA;
                    end
                end

                // An error response aborts on its first cycle, even before hready.
                ST_DATA: begin
                    if (hresp) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end else if (hready) begin
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == 1) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            s_ready <= 1'b1;
                            state   <= ST_FILL;
                        end
                    end
                end

                // Entered from DATA, done is already up. Entered from IDLE on an
                // empty job, busy is still up, so raise done here before leaving.
                ST_FIN: begin
                    if (busy) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_stream_loader.sv
// Directed bench for sram_stream_loader: an AHB slave/monitor checks every
// completed write against a scoreboard filled by the stimulus.
module tb_sram_stream_loader;
    import sram_pkg::*;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        start;
    logic [13:0] start_addr;
    logic [14:0] word_count;
    logic        busy, done, err;
    logic        s_valid, s_ready;
    logic [7:0]  s_data;
    logic        hsel, hwrite;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize;
    logic        hready = 1'b1;
    logic        hresp  = 1'b0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t       sb_q[$];
    beat_t       mon_b;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          hsel_cnt = 0;
    int          srdy_cnt = 0;
    int          last_data_cyc = 0;
    int          stall_req = 0;
    int          stall_left = 0;
    int          err_phase = 0;
    bit          err_mode = 1'b0;
    bit          in_data = 1'b0;
    logic [31:0] data_addr;

    sram_stream_loader #(.BASE_ADDR(32'h2000_0000)) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .hsel       (hsel),
        .haddr      (haddr),
        .hsize      (hsize),
        .hwrite     (hwrite),
        .hwdata     (hwdata),
        .hready     (hready),
        .hresp      (hresp)
    );

    always #5 hclk = ~hclk;

    always @(posedge hclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave model and monitor: samples DUT outputs mid-cycle and drives this cycle's response.
    always @(negedge hclk) begin
        if (hreset) begin
            in_data   = 1'b0;
            err_phase = 0;
            hready    = 1'b1;
            hresp     = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_low_at_done", busy, 1'b0);
            end
            if (s_ready) srdy_cnt++;

            if (in_data) begin
                if (err_mode) begin
                    if (err_phase == 0) begin
                        hready    = 1'b0;
                        hresp     = 1'b1;
                        err_phase = 1;
                    end else begin
                        hready    = 1'b1;
                        hresp     = 1'b1;
                        err_phase = 0;
                        in_data   = 1'b0;
                    end
                end else if (stall_left > 0) begin
                    hready = 1'b0;
                    hresp  = 1'b0;
                    stall_left--;
                    if (sb_q.size() > 0) check("hwdata_stable_in_stall", hwdata, sb_q[0].data);
                    check("s_ready_low_in_stall", s_ready, 1'b0);
                end else begin
                    hready        = 1'b1;
                    hresp         = 1'b0;
                    in_data       = 1'b0;
                    last_data_cyc = cyc;
                    if (sb_q.size() == 0) begin
                        check("unexpected_write_addr", data_addr, 32'hffff_ffff);
                    end else begin
                        mon_b = sb_q.pop_front();
                        check("write_addr", data_addr, mon_b.addr);
                        check("write_data", hwdata, mon_b.data);
                    end
                end
            end else begin
                hready = 1'b1;
                hresp  = 1'b0;
            end

            if (hsel) begin
                hsel_cnt++;
                check("hwrite_with_hsel", hwrite, 1'b1);
                check("hsize_word", hsize, 3'b010);
                if (hready) begin
                    in_data    = 1'b1;
                    data_addr  = haddr;
                    stall_left = stall_req;
                    stall_req  = 0;
                end
            end
        end
    end

    task automatic step();
        @(negedge hclk);
        #1;
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        beat_t b;
        b.addr = a;
        b.data = d;
        sb_q.push_back(b);
    endtask

    task automatic do_start(input logic [13:0] a, input logic [14:0] n);
        start      = 1'b1;
        start_addr = a;
        word_count = n;
        start_cyc  = cyc;
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic send_seq(input logic [7:0] first, input int n);
        logic [7:0] b;
        b = first;
        for (int i = 0; i < n; i++) begin
            int budget;
            budget  = 0;
            s_valid = 1'b1;
            s_data  = b;
            while (!s_ready && budget < 100) begin
                step();
                budget++;
            end
            if (!s_ready) begin
                check("s_ready_timeout", 32'(budget), 32'd0);
                s_valid = 1'b0;
                return;
            end
            step();
            b = b + 8'd1;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int budget;
        budget = 0;
        while (done_cnt == prev && budget < 200) begin
            step();
            budget++;
        end
        check("done_seen", 32'(done_cnt - prev), 32'd1);
        step();
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    busy,    1'b0);
        check({tag, "_done"},    done,    1'b0);
        check({tag, "_err"},     err,     1'b0);
        check({tag, "_s_ready"}, s_ready, 1'b0);
        check({tag, "_hsel"},    hsel,    1'b0);
        check({tag, "_hwrite"},  hwrite,  1'b0);
        check({tag, "_hsize"},   hsize,   3'b010);
        check({tag, "_haddr"},   haddr,   32'd0);
        check({tag, "_hwdata"},  hwdata,  32'd0);
    endtask

    initial begin
        int prev_done, prev_hsel, prev_srdy;

        hreset     = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        word_count = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        step();
        check_reset_outputs("reset");
        @(posedge hclk);
        #2 hreset = 1'b0;
        step();

        // Two words from 0x0010, bytes streamed back to back.
        prev_done = done_cnt;
        prev_hsel = hsel_cnt;
        expect_write(32'h2000_0040, 32'h1413_1211);
        expect_write(32'h2000_0044, 32'h1817_1615);
        do_start(14'h0010, 15'd2);
        send_seq(8'h11, 8);
        wait_done(prev_done);
        check("t1_start_to_last_data", 32'(last_data_cyc - start_cyc), 32'd12);
        check("t1_start_to_done",      32'(done_cyc - start_cyc),      32'd13);
        check("t1_err",                err,                            1'b0);
        check("t1_hsel_cycles",        32'(hsel_cnt - prev_hsel),      32'd2);
        check("t1_sb_empty",           32'(sb_q.size()),               32'd0);

        // Empty job: no bus or stream activity, done in the second cycle after start.
        prev_done = done_cnt;
        prev_hsel = hsel_cnt;
        prev_srdy = srdy_cnt;
        do_start(14'h0123, 15'd0);
        wait_done(prev_done);
        check("t2_start_to_done", 32'(done_cyc - start_cyc), 32'd2);
        check("t2_no_hsel",       32'(hsel_cnt - prev_hsel), 32'd0);
        check("t2_no_s_ready",    32'(srdy_cnt - prev_srdy), 32'd0);

        // Address wrap at the top of the window.
        prev_done = done_cnt;
        expect_write(32'h2000_FFFC, 32'hA3A2_A1A0);
        expect_write(32'h2000_0000, 32'hA7A6_A5A4);
        do_start(14'h3FFF, 15'd2);
        send_seq(8'hA0, 8);
        wait_done(prev_done);
        check("t3_sb_empty", 32'(sb_q.size()), 32'd0);

        // Slave stalls the first data phase for three cycles.
        prev_done = done_cnt;
        stall_req = 3;
        expect_write(32'h2000_0400, 32'h3433_3231);
        expect_write(32'h2000_0404, 32'h3837_3635);
        do_start(14'h0100, 15'd2);
        send_seq(8'h31, 8);
        wait_done(prev_done);
        check("t4_start_to_last_data", 32'(last_data_cyc - start_cyc), 32'd15);
        check("t4_sb_empty",           32'(sb_q.size()),               32'd0);

        // Error response on the first word aborts the job.
        prev_done = done_cnt;
        prev_hsel = hsel_cnt;
        err_mode  = 1'b1;
        do_start(14'h0020, 15'd3);
        send_seq(8'h41, 4);
        wait_done(prev_done);
        err_mode = 1'b0;
        check("t5_err_set",   err,     1'b1);
        check("t5_s_ready",   s_ready, 1'b0);
        repeat (5) step();
        check("t5_one_hsel",  32'(hsel_cnt - prev_hsel), 32'd1);
        check("t5_err_held",  err,                       1'b1);
        check("t5_sb_empty",  32'(sb_q.size()),          32'd0);

        // Next start clears the sticky error.
        prev_done = done_cnt;
        expect_write(32'h2000_0014, 32'h6463_6261);
        do_start(14'h0005, 15'd1);
        check("t5_err_cleared", err, 1'b0);
        send_seq(8'h61, 4);
        wait_done(prev_done);
        check("t5_err_after", err, 1'b0);

        // Reset after two bytes: partial word dropped, no done pulse.
        prev_done = done_cnt;
        do_start(14'h0030, 15'd1);
        send_seq(8'h55, 2);
        @(posedge hclk);
        #2 hreset = 1'b1;
        step();
        check_reset_outputs("midrst");
        @(posedge hclk);
        #2 hreset = 1'b0;
        step();
        check("t6_no_done_on_reset", 32'(done_cnt - prev_done), 32'd0);
        prev_done = done_cnt;
        expect_write(32'h2000_00C0, 32'h0403_0201);
        do_start(14'h0030, 15'd1);
        send_seq(8'h01, 4);
        wait_done(prev_done);
        check("t6_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
